// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with occupancy count, almost-full/almost-empty
// thresholds, sticky overflow/underflow flags and an optional first-word-fall-through
// read port.
//
// Parameters:
//   WIDTH    data width in bits (>= 1)
//   DEPTH    number of entries, power of two (>= 2)
//   AF_LEVEL almost_full when count >= AF_LEVEL (1..DEPTH)
//   AE_LEVEL almost_empty when count <= AE_LEVEL (0..DEPTH-1)
//   FWFT     0: registered read on pop; 1: head word shown combinationally
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst          synchronous active-high reset
//   wr_en        write request, wr_data the word to write
//   rd_en        read (pop) request
//   clr_err      clears overflow and underflow
//   rd_data      read data
//   count        occupancy 0..DEPTH
//   full/empty   count == DEPTH / count == 0
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
//   overflow     sticky, a write was rejected
//   underflow    sticky, a read was rejected
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 16,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 2,
    parameter int unsigned FWFT     = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    input  logic                     clr_err,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty,
    output logic                     almost_full,
    output logic                     almost_empty,
    output logic                     overflow,
    output logic                     underflow
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;
    logic          underflow_q, underflow_d;

    logic rd_accept;
    logic wr_accept;

    // Status flags decode only the count register, never the pointers.
    always_comb begin
        full         = (count_q == CW'(DEPTH));
        empty        = (count_q == '0);
        almost_full  = (count_q >= CW'(AF_LEVEL));
        almost_empty = (count_q <= CW'(AE_LEVEL));
        count        = count_q;
        overflow     = overflow_q;
        underflow    = underflow_q;
    end

    always_comb begin
        rd_accept = rd_en && !empty;
        // A full FIFO still takes a write when a pop frees the slot in the same cycle.
        wr_accept = wr_en && (!full || rd_accept);

        wr_ptr_d = wr_ptr_q;
        if (wr_accept) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (rd_accept) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        count_d = count_q;
        unique case ({wr_accept, rd_accept})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Setting beats a same-cycle clear.
        overflow_d  = (overflow_q && !clr_err) || (wr_en && !wr_accept);
        underflow_d = (underflow_q && !clr_err) || (rd_en && !rd_accept);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is not reset; a reset only suppresses the write in that cycle.
    always_ff @(posedge clk) begin
        if (!rst && wr_accept) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

    if (FWFT != 0) begin : g_fwft
        // Head word shown directly; forced to zero so an empty FIFO never shows stale data.
        always_comb begin
            rd_data = empty ? '0 : mem_q[rd_ptr_q];
        end
    end else begin : g_std
        logic [WIDTH-1:0] rd_data_q, rd_data_d;

        // When full with a simultaneous write, wr_ptr == rd_ptr; the old word is
        // captured here because the memory write lands at the same edge.
        always_comb begin
            rd_data_d = rd_data_q;
            if (rd_accept) begin
                rd_data_d = mem_q[rd_ptr_q];
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                rd_data_q <= '0;
            end else begin
                rd_data_q <= rd_data_d;
            end
        end

        always_comb begin
            rd_data = rd_data_q;
        end
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: a standard-read and an FWFT instance share one stimulus
// stream and are both checked every cycle against a queue-based reference model.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AF    = 3;
    localparam int unsigned AE    = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             wr_en = 1'b0;
    logic [WIDTH-1:0] wr_data = '0;
    logic             rd_en = 1'b0;
    logic             clr_err = 1'b0;

    logic [WIDTH-1:0] s_rd_data, f_rd_data;
    logic [2:0]       s_count, f_count;
    logic             s_full, s_empty, s_af, s_ae, s_ovf, s_unf;
    logic             f_full, f_empty, f_af, f_ae, f_ovf, f_unf;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state.
    logic [WIDTH-1:0] q[$];
    logic [WIDTH-1:0] m_rd_std = '0;
    logic             m_ovf = 1'b0;
    logic             m_unf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(0)
    ) dut_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(s_rd_data), .count(s_count), .full(s_full),
        .empty(s_empty), .almost_full(s_af), .almost_empty(s_ae),
        .overflow(s_ovf), .underflow(s_unf)
    );

    sync_fifo_param #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .FWFT(1)
    ) dut_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
        .clr_err(clr_err), .rd_data(f_rd_data), .count(f_count), .full(f_full),
        .empty(f_empty), .almost_full(f_af), .almost_empty(f_ae),
        .overflow(f_ovf), .underflow(f_unf)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Apply the FIFO rules to the queue for one clock edge.
    task automatic model_edge(input logic w, input logic [WIDTH-1:0] d, input logic r,
                              input logic c, input logic rs);
        logic rd_ok, wr_ok;
        if (rs) begin
            q.delete();
            m_rd_std = '0;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            rd_ok = r && (q.size() > 0);
            wr_ok = w && ((q.size() < DEPTH) || rd_ok);
            if (rd_ok) m_rd_std = q.pop_front();
            if (wr_ok) q.push_back(d);
            m_ovf = (m_ovf && !c) || (w && !wr_ok);
            m_unf = (m_unf && !c) || (r && !rd_ok);
        end
    endtask

    task automatic check_all();
        int unsigned n;
        logic [WIDTH-1:0] head;
        n    = q.size();
        head = (n > 0) ? q[0] : '0;
        check_eq("count",        32'(s_count), n);
        check_eq("full",         32'(s_full), 32'(n == DEPTH));
        check_eq("empty",        32'(s_empty), 32'(n == 0));
        check_eq("almost_full",  32'(s_af), 32'(n >= AF));
        check_eq("almost_empty", 32'(s_ae), 32'(n <= AE));
        check_eq("overflow",     32'(s_ovf), 32'(m_ovf));
        check_eq("underflow",    32'(s_unf), 32'(m_unf));
        check_eq("rd_data_std",  32'(s_rd_data), 32'(m_rd_std));
        check_eq("fwft_count",   32'(f_count), n);
        check_eq("fwft_empty",   32'(f_empty), 32'(n == 0));
        check_eq("fwft_full",    32'(f_full), 32'(n == DEPTH));
        check_eq("fwft_flags",   {30'd0, f_ovf, f_unf}, {30'd0, m_ovf, m_unf});
        check_eq("rd_data_fwft", 32'(f_rd_data), 32'(head));
    endtask

    // Drive one cycle, let the edge happen, then compare 1 time unit later.
    task automatic cycle(input logic w, input logic [WIDTH-1:0] d, input logic r,
                         input logic c, input logic rs);
        wr_en   = w;
        wr_data = d;
        rd_en   = r;
        clr_err = c;
        rst     = rs;
        @(posedge clk);
        model_edge(w, d, r, c, rs);
        #1;
        check_all();
    endtask

    logic [WIDTH-1:0] fill_vals [4];
    logic [WIDTH-1:0] nb;

    initial begin
        fill_vals[0] = 8'h11; fill_vals[1] = 8'h22;
        fill_vals[2] = 8'h33; fill_vals[3] = 8'h44;

        // Reset with random requests in flight.
        for (int i = 0; i < 2; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b1);
        end
        check_eq("reset_empty", 32'(s_empty), 32'd1);
        check_eq("reset_ae",    32'(s_ae), 32'd1);

        // Fill and overflow.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0);
            if (i == 1) check_eq("af_before_third", 32'(s_af), 32'd0);
            if (i == 2) check_eq("af_after_third", 32'(s_af), 32'd1);
            if (i == 3) check_eq("full_after_fourth", 32'(s_full), 32'd1);
        end
        cycle(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        check_eq("overflow_set", 32'(s_ovf), 32'd1);
        check_eq("count_stays_4", 32'(s_count), 32'd4);
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
            check_eq("drain_data", 32'(s_rd_data), 32'(fill_vals[i]));
        end

        // Underflow, then clear.
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("underflow_set", 32'(s_unf), 32'd1);
        cycle(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_eq("clr_err_ovf", 32'(s_ovf), 32'd0);
        check_eq("clr_err_unf", 32'(s_unf), 32'd0);

        // Full with simultaneous read and write.
        for (int i = 0; i < 4; i++) cycle(1'b1, fill_vals[i], 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 8'hA0 + 8'(i), 1'b1, 1'b0, 1'b0);
            check_eq("rw_full_data", 32'(s_rd_data), 32'(fill_vals[i]));
            check_eq("rw_full_flag", 32'(s_full), 32'd1);
            check_eq("rw_full_ovf", 32'(s_ovf), 32'd0);
        end

        // Wrap-around stream with mixed single and dual operations.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        nb = 8'h00;
        while (nb < 8'(3 * DEPTH)) begin
            case ($urandom_range(0, 2))
                0: begin cycle(1'b1, nb, 1'b0, 1'b0, 1'b0); nb++; end
                1: cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
                default: begin cycle(1'b1, nb, 1'b1, 1'b0, 1'b0); nb++; end
            endcase
        end
        while (q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);

        // FWFT head visibility.
        cycle(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);
        check_eq("fwft_head", 32'(f_rd_data), 32'h5A);
        check_eq("fwft_not_empty", 32'(f_empty), 32'd0);
        cycle(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        check_eq("fwft_pop_empty", 32'(f_empty), 32'd1);
        check_eq("fwft_pop_zero", 32'(f_rd_data), 32'd0);

        // Random traffic with occasional clears and resets.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Parametrised single-clock FIFO: the next generation of the team's FIFO block, generalised in data width and depth. It adds programmable almost-full and almost-empty thresholds, a live occupancy count, sticky overflow/underflow error flags and a selectable first-word-fall-through (FWFT) read mode. It buffers byte or word streams between producer and consumer logic inside a Tiny Tapeout user project that runs on one clock.

## Interface
- WIDTH, 8: data width in bits, 1 or more.
- DEPTH, 16: number of entries; a power of two, 2 or more.
- AF_LEVEL, DEPTH-2: almost_full asserts when count >= AF_LEVEL; range 1..DEPTH.
- AE_LEVEL, 2: almost_empty asserts when count <= AE_LEVEL; range 0..DEPTH-1.
- FWFT, 0: 0 selects standard registered read; 1 selects first-word-fall-through.
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- wr_en  in  1  write request.
- wr_data  in  WIDTH  write data.
- rd_en  in  1  read (pop) request.
- clr_err  in  1  clears overflow and underflow.
- rd_data  out  WIDTH  read data.
- count  out  $clog2(DEPTH)+1  occupancy, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count >= AF_LEVEL.
- almost_empty  out  1  count <= AE_LEVEL.
- overflow  out  1  sticky; a write was rejected.
- underflow  out  1  sticky; a read was rejected.

## Operation
- Storage: DEPTH x WIDTH array. wr_ptr and rd_ptr are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is an explicit register.
- rd_accept = rd_en && !empty.
- wr_accept = wr_en && (!full || rd_accept). A write into a full FIFO is accepted only when a read is accepted in the same cycle.
- count update: +1 on write only, -1 on read only, unchanged when both or neither are accepted.
- Flags are combinational decodes of the count register. Flags never come from pointer comparison.
- Standard mode (FWFT=0): an accepted read loads mem[rd_ptr] into the rd_data register. rd_data holds its value until the next accepted read.
- FWFT mode (FWFT=1): rd_data = mem[rd_ptr] whenever !empty, and rd_data = 0 when empty. rd_en acknowledges and pops the head word.
- Errors:
  - wr_en && !wr_accept sets overflow.
  - rd_en && !rd_accept sets underflow.
  - Both flags hold until clr_err or rst.
  - When set and clr_err occur in the same cycle, set wins.
- Rejected operations leave the pointers, count and memory unchanged.
- Write into an empty FIFO with a simultaneous rd_en: the read is rejected and underflow is set; the write is accepted.

## Timing
- Reset values: rd_data=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0; both pointers 0.
- Memory contents are not reset.
- rst asserted mid-operation discards all contents at that edge and overrides any same-cycle wr_en or rd_en.
- Write latency: a word written at edge N raises count and clears empty after edge N.
- Standard read latency: a pop at edge N gives valid rd_data after edge N, so the data is usable in cycle N+1.
- FWFT: the head word is visible on rd_data in the cycle after the write edge that took the FIFO from empty.
- Throughput: one write and one read per cycle, sustained, at any fill level, including full with both requests asserted.
- No combinational path from wr_en or rd_en to any output. In FWFT mode the only combinational path is from the pointer/memory to rd_data.

## Test plan
- Reset: hold rst for 2 cycles with random wr_en/rd_en. Required: every output at its reset value; count=0, empty=1, almost_empty=1.
- Fill and overflow (DEPTH=4, AF_LEVEL=3, FWFT=0): write 0x11, 0x22, 0x33, 0x44.
  - Required: almost_full rises after the third write, full after the fourth.
  - A fifth write of 0x55 sets overflow; count stays 4.
  - Drain: rd_data gives 0x11, 0x22, 0x33, 0x44, each one cycle after its pop.
- Underflow and clear: rd_en on an empty FIFO sets underflow, count stays 0. Pulse clr_err alone: underflow and overflow return to 0.
- Full with simultaneous read and write: with the FIFO full, drive wr_en and rd_en for 3 cycles with new data 0xA0..0xA2.
  - Required: full stays 1, count stays 4, overflow stays 0.
  - The oldest words pop in order.
- Wrap-around: stream 3*DEPTH incrementing bytes with interleaved single and dual operations. Required: output is in order with no loss; pointers wrap cleanly.
- FWFT (FWFT=1): write 0x5A into an empty FIFO.
  - Required: rd_data=0x5A and empty=0 in the next cycle.
  - Assert rd_en: after that edge, empty=1 and rd_data=0.
